// File: rtl/branch_resolve_unit.sv
// Branch resolution and 2-bit-counter prediction unit: resolves EX-stage branches,
// trains a PC-indexed counter table, and flags mispredictions with a one-cycle redirect.
module branch_resolve_unit #(
   parameter int unsigned DATA_BITS      = 32,
   parameter int unsigned ADDR_BITS      = 32,
   parameter int unsigned BHT_INDEX_BITS = 6,
   parameter int unsigned CNT_BITS       = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [ADDR_BITS-1:0] i_if_pc,
   output logic                 o_if_pred_taken,
   input  logic                 i_ex_valid,
   input  logic                 i_ex_stall,
   input  logic [2:0]           i_ex_cond,
   input  logic [ADDR_BITS-1:0] i_ex_pc,
   input  logic [ADDR_BITS-1:0] i_ex_target,
   input  logic [DATA_BITS-1:0] i_ex_rs,
   input  logic [DATA_BITS-1:0] i_ex_rt,
   input  logic                 i_ex_pred_taken,
   output logic                 o_pcsel,
   output logic                 o_mispredict,
   output logic [ADDR_BITS-1:0] o_redirect_pc,
   output logic [CNT_BITS-1:0]  o_branch_cnt,
   output logic [CNT_BITS-1:0]  o_mispredict_cnt
);

   localparam int BhtDepth = 1 << BHT_INDEX_BITS;

   typedef enum logic [2:0] {
      CondNone = 3'd0,
      CondBeq  = 3'd1,
      CondBne  = 3'd2,
      CondBltz = 3'd3,
      CondBgtz = 3'd4,
      CondBlez = 3'd5,
      CondBgez = 3'd6,
      CondRsvd = 3'd7
   } cond_e;

   typedef enum logic [1:0] {
      StStrongNt = 2'd0,
      StWeakNt   = 2'd1,
      StWeakT    = 2'd2,
      StStrongT  = 2'd3
   } bht_state_e;

   bht_state_e                r_bht [BhtDepth];
   logic                      r_pcsel;
   logic                      r_mispredict;
   logic [ADDR_BITS-1:0]      r_redirect_pc;
   logic [CNT_BITS-1:0]       r_branch_cnt;
   logic [CNT_BITS-1:0]       r_mispredict_cnt;

   cond_e                     w_cond;
   logic                      w_is_branch;
   logic                      w_act;
   logic                      w_taken;
   logic                      w_mispredict;
   logic                      w_rs_neg;
   logic                      w_rs_zero;
   logic [BHT_INDEX_BITS-1:0] w_if_idx;
   logic [BHT_INDEX_BITS-1:0] w_ex_idx;
   bht_state_e                w_bht_cur;
   bht_state_e                w_bht_next;
   logic [ADDR_BITS-1:0]      w_fall_through;
   logic [ADDR_BITS-1:0]      w_next_pc;
   logic                      w_unused_pc_bits;

   assign w_cond    = cond_e'(i_ex_cond);
   assign w_if_idx  = i_if_pc[BHT_INDEX_BITS+1:2];
   assign w_ex_idx  = i_ex_pc[BHT_INDEX_BITS+1:2];
   assign w_rs_neg  = i_ex_rs[DATA_BITS-1];
   assign w_rs_zero = (i_ex_rs == '0);

   // Only the word-index bits of the fetch PC address the table.
   assign w_unused_pc_bits = ^{i_if_pc[ADDR_BITS-1:BHT_INDEX_BITS+2], i_if_pc[1:0]};

   always_comb begin
      w_is_branch = 1'b0;
      w_taken     = 1'b0;
      unique case (w_cond)
         CondBeq:  begin w_is_branch = 1'b1; w_taken = (i_ex_rs == i_ex_rt);     end
         CondBne:  begin w_is_branch = 1'b1; w_taken = (i_ex_rs != i_ex_rt);     end
         CondBltz: begin w_is_branch = 1'b1; w_taken = w_rs_neg;                 end
         CondBgtz: begin w_is_branch = 1'b1; w_taken = !w_rs_neg && !w_rs_zero;  end
         CondBlez: begin w_is_branch = 1'b1; w_taken = w_rs_neg || w_rs_zero;    end
         CondBgez: begin w_is_branch = 1'b1; w_taken = !w_rs_neg;                end
         CondNone, CondRsvd: begin
            w_is_branch = 1'b0;
            w_taken     = 1'b0;
         end
         default: begin
            w_is_branch = 1'b0;
            w_taken     = 1'b0;
         end
      endcase
   end

   assign w_act          = i_ex_valid && !i_ex_stall && w_is_branch;
   assign w_mispredict   = (w_taken != i_ex_pred_taken);
   // Fall-through skips the delay slot; wraps at the top of the address space.
   assign w_fall_through = i_ex_pc + ADDR_BITS'(8);
   assign w_next_pc      = w_taken ? i_ex_target : w_fall_through;

   assign w_bht_cur = r_bht[w_ex_idx];

   always_comb begin
      w_bht_next = w_bht_cur;
      if (w_taken) begin
         if (w_bht_cur != StStrongT) begin
            w_bht_next = bht_state_e'(w_bht_cur + 2'd1);
         end
      end else begin
         if (w_bht_cur != StStrongNt) begin
            w_bht_next = bht_state_e'(w_bht_cur - 2'd1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < BhtDepth; i++) begin
            r_bht[i] <= StWeakNt;
         end
      end else if (w_act) begin
         r_bht[w_ex_idx] <= w_bht_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pcsel       <= 1'b0;
         r_mispredict  <= 1'b0;
         r_redirect_pc <= '0;
      end else if (w_act) begin
         r_pcsel       <= w_taken;
         r_mispredict  <= w_mispredict;
         r_redirect_pc <= w_next_pc;
      end else begin
         r_pcsel       <= 1'b0;
         r_mispredict  <= 1'b0;
         r_redirect_pc <= '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_branch_cnt     <= '0;
         r_mispredict_cnt <= '0;
      end else if (w_act) begin
         r_branch_cnt <= r_branch_cnt + CNT_BITS'(1);
         if (w_mispredict) begin
            r_mispredict_cnt <= r_mispredict_cnt + CNT_BITS'(1);
         end
      end
   end

   // Read is from the current table, so a same-cycle update shows up one cycle later.
   assign o_if_pred_taken  = r_bht[w_if_idx][1];
   assign o_pcsel          = r_pcsel;
   assign o_mispredict     = r_mispredict;
   assign o_redirect_pc    = r_redirect_pc;
   assign o_branch_cnt     = r_branch_cnt;
   assign o_mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table for resolution plus hand sequences
// for reset, training/saturation, stall and counter wrap (CNT_BITS = 4).
module tb_branch_resolve_unit;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        ex_valid;
   logic        ex_stall;
   logic [2:0]  ex_cond;
   logic [31:0] ex_pc;
   logic [31:0] ex_target;
   logic [31:0] ex_rs;
   logic [31:0] ex_rt;
   logic        ex_pred_taken;
   logic        pcsel;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [3:0]  branch_cnt;
   logic [3:0]  mispredict_cnt;

   int n_checks;
   int n_errors;
   int exp_br;
   int exp_mp;

   typedef struct {
      logic [2:0]  cond;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        pred;
      logic        act;
      logic        taken;
      logic [31:0] redir;
   } vec_t;

   vec_t vecs [12];

   branch_resolve_unit #(
      .DATA_BITS      (32),
      .ADDR_BITS      (32),
      .BHT_INDEX_BITS (6),
      .CNT_BITS       (4)
   ) u_dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_if_pc          (if_pc),
      .o_if_pred_taken  (if_pred_taken),
      .i_ex_valid       (ex_valid),
      .i_ex_stall       (ex_stall),
      .i_ex_cond        (ex_cond),
      .i_ex_pc          (ex_pc),
      .i_ex_target      (ex_target),
      .i_ex_rs          (ex_rs),
      .i_ex_rt          (ex_rt),
      .i_ex_pred_taken  (ex_pred_taken),
      .o_pcsel          (pcsel),
      .o_mispredict     (mispredict),
      .o_redirect_pc    (redirect_pc),
      .o_branch_cnt     (branch_cnt),
      .o_mispredict_cnt (mispredict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [2:0] cond, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [31:0] pc,
                               input logic [31:0] tgt, input logic pred, input logic act,
                               input logic taken, input logic [31:0] redir);
      vec_t v;
      v.cond = cond; v.rs = rs; v.rt = rt; v.pc = pc; v.tgt = tgt;
      v.pred = pred; v.act = act; v.taken = taken; v.redir = redir;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_counts(input string name);
      chk({name, " branch_cnt"}, 32'(branch_cnt), 32'(exp_br % 16));
      chk({name, " mispredict_cnt"}, 32'(mispredict_cnt), 32'(exp_mp % 16));
   endtask

   // Drives one branch; expected counts come from the bench's own taken value.
   task automatic drive(input logic [2:0] cond, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                        input logic exp_taken);
      ex_valid = 1'b1; ex_stall = 1'b0; ex_cond = cond; ex_rs = rs; ex_rt = rt;
      ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
      exp_br++;
      if (exp_taken != pred) exp_mp++;
   endtask

   task automatic idle();
      ex_valid = 1'b0; ex_stall = 1'b0; ex_cond = 3'd0;
   endtask

   initial begin
      n_checks = 0; n_errors = 0; exp_br = 0; exp_mp = 0;
      rst = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_stall = 1'b0; ex_cond = '0;
      ex_pc = '0; ex_target = '0; ex_rs = '0; ex_rt = '0; ex_pred_taken = 1'b0;

      vecs[0]  = mk(3'd3, 32'h8000_0000, 32'h0, 32'h0040_0030, 32'h0040_0200, 1'b0,
                    1'b1, 1'b1, 32'h0040_0200);
      vecs[1]  = mk(3'd6, 32'h0, 32'h0, 32'h0040_0040, 32'h0040_0300, 1'b1,
                    1'b1, 1'b1, 32'h0040_0300);
      vecs[2]  = mk(3'd4, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'h0040_0400, 1'b0,
                    1'b1, 1'b0, 32'h0000_0000);
      vecs[3]  = mk(3'd2, 32'h55, 32'h55, 32'h0040_0020, 32'h0040_0500, 1'b1,
                    1'b1, 1'b0, 32'h0040_0028);
      vecs[4]  = mk(3'd3, 32'h0, 32'h0, 32'h0040_0060, 32'h0040_0600, 1'b0,
                    1'b1, 1'b0, 32'h0040_0068);
      vecs[5]  = mk(3'd4, 32'h7FFF_FFFF, 32'h0, 32'h0040_0064, 32'h0040_0700, 1'b1,
                    1'b1, 1'b1, 32'h0040_0700);
      vecs[6]  = mk(3'd5, 32'hFFFF_FFFF, 32'h0, 32'h0040_0068, 32'h0040_0800, 1'b0,
                    1'b1, 1'b1, 32'h0040_0800);
      vecs[7]  = mk(3'd5, 32'h1, 32'h0, 32'h0040_006C, 32'h0040_0900, 1'b0,
                    1'b1, 1'b0, 32'h0040_0074);
      vecs[8]  = mk(3'd6, 32'hFFFF_FFFF, 32'h0, 32'h0040_0070, 32'h0040_0A00, 1'b1,
                    1'b1, 1'b0, 32'h0040_0078);
      vecs[9]  = mk(3'd2, 32'h1, 32'h2, 32'h0040_0074, 32'h0040_0B00, 1'b1,
                    1'b1, 1'b1, 32'h0040_0B00);
      vecs[10] = mk(3'd0, 32'h1, 32'h1, 32'h0040_0078, 32'h0040_0C00, 1'b0,
                    1'b0, 1'b0, 32'h0);
      vecs[11] = mk(3'd7, 32'h1, 32'h1, 32'h0040_007C, 32'h0040_0D00, 1'b1,
                    1'b0, 1'b0, 32'h0);

      // Reset
      step(); step();
      chk("rst pcsel", 32'(pcsel), 32'd0);
      chk("rst mispredict", 32'(mispredict), 32'd0);
      chk("rst redirect_pc", redirect_pc, 32'd0);
      chk_counts("rst");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if_pc = 32'h0040_0000 + 32'(i * 52);
         #1;
         chk("rst if_pred_taken", 32'(if_pred_taken), 32'd0);
      end

      // BEQ taken, predicted not-taken
      drive(3'd1, 32'h1234, 32'h1234, 32'h0040_0010, 32'h0040_0100, 1'b0, 1'b1);
      step();
      idle();
      chk("beq pcsel", 32'(pcsel), 32'd1);
      chk("beq mispredict", 32'(mispredict), 32'd1);
      chk("beq redirect_pc", redirect_pc, 32'h0040_0100);
      chk_counts("beq");
      step();
      if_pc = 32'h0040_0010;
      #1;
      chk("beq pulse end", 32'(mispredict), 32'd0);
      chk("beq idle redirect", redirect_pc, 32'd0);
      chk("beq trained pred", 32'(if_pred_taken), 32'd1);

      // Table vectors, back-to-back
      for (int i = 0; i < 12; i++) begin
         ex_valid = 1'b1; ex_stall = 1'b0; ex_cond = vecs[i].cond;
         ex_rs = vecs[i].rs; ex_rt = vecs[i].rt; ex_pc = vecs[i].pc;
         ex_target = vecs[i].tgt; ex_pred_taken = vecs[i].pred;
         if (vecs[i].act) begin
            exp_br++;
            if (vecs[i].taken != vecs[i].pred) exp_mp++;
         end
         step();
         chk($sformatf("vec%0d pcsel", i), 32'(pcsel), 32'(vecs[i].taken));
         chk($sformatf("vec%0d mispredict", i), 32'(mispredict),
             32'(vecs[i].act && (vecs[i].taken != vecs[i].pred)));
         chk($sformatf("vec%0d redirect_pc", i), redirect_pc, vecs[i].redir);
         chk_counts($sformatf("vec%0d", i));
      end
      idle();

      // Saturation and same-cycle fetch/update at 0x00400080
      if_pc = 32'h0040_0080;
      drive(3'd1, 32'h9, 32'h9, 32'h0040_0080, 32'h0040_1000, 1'b1, 1'b1);
      #1;
      chk("sat pre-update pred", 32'(if_pred_taken), 32'd0);
      step();
      chk("sat after 1 taken", 32'(if_pred_taken), 32'd1);
      for (int i = 0; i < 3; i++) begin
         drive(3'd1, 32'h9, 32'h9, 32'h0040_0080, 32'h0040_1000, 1'b1, 1'b1);
         step();
      end
      drive(3'd1, 32'h9, 32'h8, 32'h0040_0080, 32'h0040_1000, 1'b1, 1'b0);
      step();
      chk("sat nt mispredict", 32'(mispredict), 32'd1);
      chk("sat nt redirect", redirect_pc, 32'h0040_0088);
      chk("sat 3->2 pred", 32'(if_pred_taken), 32'd1);
      drive(3'd1, 32'h9, 32'h8, 32'h0040_0080, 32'h0040_1000, 1'b1, 1'b0);
      step();
      chk("sat 2->1 pred", 32'(if_pred_taken), 32'd0);
      chk_counts("sat");

      // Stall: same mispredicting branch held for 3 cycles
      ex_valid = 1'b1; ex_stall = 1'b1; ex_cond = 3'd1;
      ex_rs = 32'h7; ex_rt = 32'h7; ex_pc = 32'h0040_0084; ex_target = 32'h0040_2000;
      ex_pred_taken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall mispredict", 32'(mispredict), 32'd0);
         chk("stall pcsel", 32'(pcsel), 32'd0);
         chk_counts("stall");
      end
      drive(3'd1, 32'h7, 32'h7, 32'h0040_0084, 32'h0040_2000, 1'b0, 1'b1);
      step();
      idle();
      chk("unstall mispredict", 32'(mispredict), 32'd1);
      chk("unstall redirect", redirect_pc, 32'h0040_2000);
      chk_counts("unstall");

      // Reset overrides a simultaneous act and reinitialises the table
      drive(3'd1, 32'h3, 32'h3, 32'h0040_0080, 32'h0040_3000, 1'b0, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle();
      exp_br = 0; exp_mp = 0;
      if_pc = 32'h0040_0010;
      #1;
      chk("rst-act pcsel", 32'(pcsel), 32'd0);
      chk("rst-act mispredict", 32'(mispredict), 32'd0);
      chk("rst-act table", 32'(if_pred_taken), 32'd0);
      chk_counts("rst-act");

      // Wrap of the 4-bit branch counter
      for (int i = 0; i < 15; i++) begin
         drive(3'd6, 32'h0, 32'h0, 32'h0040_0090, 32'h0040_4000, 1'b1, 1'b1);
         step();
      end
      chk("wrap cnt 15", 32'(branch_cnt), 32'd15);
      drive(3'd6, 32'h0, 32'h0, 32'h0040_0090, 32'h0040_4000, 1'b1, 1'b1);
      step();
      idle();
      chk("wrap cnt 0", 32'(branch_cnt), 32'd0);
      chk("wrap mispredict_cnt", 32'(mispredict_cnt), 32'd0);
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution and prediction unit for the pipelined MIPS core. It evaluates all conditional branch types (BEQ/BNE/BLTZ/BGTZ/BLEZ/BGEZ) on EX-stage operands and registers the outcome. It also owns a PC-indexed table of 2-bit saturating counters that supplies a taken/not-taken prediction to IF, detects mispredictions, and emits a one-cycle redirect. Two wrapping performance counters track resolved branches and mispredictions.

## Interface
Parameters:
- DATA_BITS, 32, operand width
- ADDR_BITS, 32, PC width
- BHT_INDEX_BITS, 6, log2 of table depth (depth = 2^BHT_INDEX_BITS)
- CNT_BITS, 32, width of performance counters

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- if_pc  in  ADDR_BITS  fetch PC; table index = if_pc[BHT_INDEX_BITS+1:2]
- if_pred_taken  out  1  combinational: MSB of the counter at the fetch index
- ex_valid  in  1  EX holds a branch candidate this cycle
- ex_stall  in  1  pipeline stalled; EX input is ignored this cycle
- ex_cond  in  3  0 none, 1 BEQ, 2 BNE, 3 BLTZ, 4 BGTZ, 5 BLEZ, 6 BGEZ, 7 reserved (treated as none)
- ex_pc  in  ADDR_BITS  branch PC
- ex_target  in  ADDR_BITS  taken target
- ex_rs, ex_rt  in  DATA_BITS  operands; compares are signed for the zero tests
- ex_pred_taken  in  1  prediction carried down from IF with this branch
- pcsel  out  1  registered actual branch outcome
- mispredict  out  1  registered one-cycle pulse
- redirect_pc  out  ADDR_BITS  registered correct next PC, valid while mispredict=1
- branch_cnt, mispredict_cnt  out  CNT_BITS  performance counters

## Operation
- A resolve event (`act`) is ex_valid & !ex_stall & ex_cond in 1..6. Every other cycle is idle.
- Taken conditions:
  - BEQ: rs==rt
  - BNE: rs!=rt
  - BLTZ: $signed(rs)<0
  - BGTZ: $signed(rs)>0
  - BLEZ: $signed(rs)<=0
  - BGEZ: $signed(rs)>=0
- On an `act` edge:
  - pcsel <= taken.
  - mispredict <= (taken != ex_pred_taken).
  - redirect_pc <= taken ? ex_target : ex_pc+8. The fall-through skips the delay slot; the addition is ADDR_BITS wide and wraps modulo 2^ADDR_BITS.
  - branch_cnt increments.
  - mispredict_cnt increments if mispredict.
  - Counter at index ex_pc[BHT_INDEX_BITS+1:2] is updated: +1 saturating at 3 if taken, -1 saturating at 0 if not taken.
- On an idle edge: pcsel, mispredict and redirect_pc go to 0. Table and counters are unchanged.
- Counter states: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. Prediction is taken when state >= 2.
- Performance counters wrap from 2^CNT_BITS-1 to 0.
- Fetch and update at the same index in the same cycle: if_pred_taken shows the pre-update value in that cycle and the new value from the next cycle on.
- The block does not self-suppress wrong-path branches. The pipeline must deassert ex_valid for flushed instructions.

## Timing
- Reset (rst high at an edge) sets:
  - pcsel=0, mispredict=0, redirect_pc=0
  - branch_cnt=0, mispredict_cnt=0
  - all table entries = 1 (weak-NT)
  - Reset overrides a simultaneous `act`. Reset mid-stream discards any in-flight result.
- Outcome latency: 1 cycle. Results of an `act` at edge N are visible from edge N until edge N+1.
- mispredict is exactly one cycle per mispredicting branch. Back-to-back `act` cycles each produce their own independent pulse.
- ex_stall high overrides ex_valid: no update and no double-count. The same branch is presented again when the stall drops.
- if_pred_taken is purely combinational from if_pc and the table; it has no clock latency.

## Test plan
- Reset: assert rst 2 cycles, then check all outputs are 0 and if_pred_taken=0 for 4 sampled PCs.
- BEQ mispredict:
  - Stimulus: ex_cond=1, rs=rt=0x1234, ex_pc=0x00400010, ex_target=0x00400100, ex_pred_taken=0.
  - Next cycle: pcsel=1, mispredict=1, redirect_pc=0x00400100, branch_cnt=1, mispredict_cnt=1.
  - Following cycle: mispredict=0, and if_pred_taken at 0x00400010 is 1 (state 2).
- Signed zero tests:
  - BLTZ with rs=0x80000000 gives taken.
  - BGEZ with rs=0 gives taken.
  - BGTZ with rs=0 gives not-taken; with pred=0 there is no mispredict and redirect_pc=0.
- BNE not-taken mispredict: rs=rt, ex_pred_taken=1, ex_pc=0x00400020 gives mispredict=1 and redirect_pc=0x00400028.
- Saturation: 4 taken BEQs at one PC leave state 3; a single not-taken then leaves state 2, so if_pred_taken stays 1.
- Stall and wrap:
  - ex_valid=1 with ex_stall=1 for 3 cycles causes no count change and no pulse.
  - With CNT_BITS=4, 16 resolved branches return branch_cnt to 0.
